// File: rtl/usr_serial_ctrl_pkg.sv
// Shared types and constants for the universal-shift-register serial lane
// controller (usr_serial_ctrl) and its shift register (usr_lane).
//   state_t - controller sequencing states
//   MODE_*  - operation select for usr_lane
package usr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_serial_ctrl_if.sv
// Parallel-side bus of usr_serial_ctrl: transmit handshake with per-word
// configuration, plus the received-word output.
//   tx_valid/tx_ready/tx_data - word offered by the producer
//   msb_first, div            - shift direction and bit period (div+1 clocks)
//   rx_valid/rx_data          - received word strobe and value
// Modports: master = producer/consumer side, slave = controller side.
interface usr_serial_ctrl_if #(
    parameter int N     = 8,
    parameter int DIV_W = 8
);
    logic             tx_valid;
    logic             tx_ready;
    logic [N-1:0]     tx_data;
    logic             msb_first;
    logic [DIV_W-1:0] div;
    logic             rx_valid;
    logic [N-1:0]     rx_data;

    modport master (
        output tx_valid, tx_data, msb_first, div,
        input  tx_ready, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, msb_first, div,
        output tx_ready, rx_valid, rx_data
    );
endinterface

// File: rtl/usr_serial_ctrl_lane.sv
// usr_lane: N-bit universal shift register (hold / shift right / shift left /
// parallel load).
//   clk, rst  - clock, asynchronous active-high reset (Q clears to 0)
//   mode      - MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD
//   p_data    - parallel load value
//   sin_left  - bit entering at the MSB on a right shift
//   sin_right - bit entering at the LSB on a left shift
//   q         - register contents
module usr_lane
    import usr_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic [N-1:0] p_data,
    input  logic         sin_left,
    input  logic         sin_right,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (mode)
                MODE_LOAD: q <= p_data;
                MODE_SHL:  q <= {q[N-2:0], sin_right};
                MODE_SHR:  q <= {sin_left, q[N-1:1]};
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/usr_serial_ctrl.sv
// usr_serial_ctrl: sequencer that turns a usr_lane shift register into a
// full-duplex serial lane. A parallel word is loaded on the tx handshake,
// shifted out on sdo over N bit periods of div+1 clocks while sdi is shifted
// into the vacated bit, and the received word is presented with a one-cycle
// rx_valid strobe.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - usr_serial_ctrl_if.slave (tx handshake, msb_first, div, rx word)
//   abort     - synchronous cancel; also blocks acceptance in IDLE
//   sdi, sdo  - serial in / out
//   loopback  - only with USR_CTRL_LOOPBACK_EN: shift in sdo instead of sdi
//   busy      - transfer in progress (state != IDLE)
// Build option: define USR_CTRL_LOOPBACK_EN to add the loopback input.
module usr_serial_ctrl
    import usr_ctrl_pkg::*;
#(
    parameter int N     = 8,
    parameter int DIV_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    usr_serial_ctrl_if.slave   bus,
    input  logic               abort,
    input  logic               sdi,
`ifdef USR_CTRL_LOOPBACK_EN
    input  logic               loopback,
`endif
    output logic               sdo,
    output logic               busy
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    state_t           state;
    logic [N-1:0]     q;
    logic [N-1:0]     shifted;
    logic [1:0]       mode;
    logic             sin;
    logic             msb_l;
    logic [DIV_W-1:0] div_l;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             sdo_r;
    logic             rx_valid_r;
    logic [N-1:0]     rx_data_r;
    logic             accept;
    logic             shift_now;

`ifdef USR_CTRL_LOOPBACK_EN
    // sdo_r always holds the bit leaving the register, so looping it back
    // rotates the word and the received word equals the transmitted one.
    assign sin = loopback ? sdo_r : sdi;
`else
    assign sin = sdi;
`endif

    assign accept    = (state == IDLE) && bus.tx_valid && !abort;
    assign shift_now = (state == SHIFT) && !abort && (div_cnt == '0);

    // Value the lane will hold after this cycle's shift; used to present the
    // final word in the same cycle the lane captures it, and to pick the next
    // outgoing bit.
    assign shifted = msb_l ? {q[N-2:0], sin} : {sin, q[N-1:1]};

    always_comb begin
        mode = MODE_HOLD;
        if (accept) begin
            mode = MODE_LOAD;
        end else if (shift_now) begin
            mode = msb_l ? MODE_SHL : MODE_SHR;
        end
    end

    usr_lane #(.N(N)) u_lane (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .p_data    (bus.tx_data),
        .sin_left  (sin),
        .sin_right (sin),
        .q         (q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            msb_l      <= 1'b0;
            div_l      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sdo_r      <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= '0;
        end else begin
            rx_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        msb_l   <= bus.msb_first;
                        div_l   <= bus.div;
                        div_cnt <= bus.div;
                        bit_cnt <= '0;
                        sdo_r   <= bus.msb_first ? bus.tx_data[N-1] : bus.tx_data[0];
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                        sdo_r <= 1'b0;
                    end else if (div_cnt == '0) begin
                        div_cnt <= div_l;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state      <= DONE;
                            sdo_r      <= 1'b0;
                            rx_valid_r <= 1'b1;
                            rx_data_r  <= shifted;
                        end else begin
                            sdo_r <= msb_l ? shifted[N-1] : shifted[0];
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sdo          = sdo_r;
    assign busy         = (state != IDLE);
    assign bus.tx_ready = (state == IDLE) && !abort;
    // An abort in the DONE cycle suppresses the strobe it would have produced.
    assign bus.rx_valid = rx_valid_r && !abort;
    assign bus.rx_data  = rx_data_r;

endmodule

// File: tb/tb_usr_serial_ctrl.sv
// Self-checking bench for usr_serial_ctrl (N=8, DIV_W=8). Expected received
// words are queued when a transfer is accepted and compared when rx_valid
// fires. With USR_CTRL_LOOPBACK_EN defined, a loopback transfer is added.
module tb_usr_serial_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic abort;
    logic sdi;
    logic sdo;
    logic busy;
    logic loopback;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb[$];
    logic [7:0] last_rx;

    usr_serial_ctrl_if #(.N(8), .DIV_W(8)) bus ();

    usr_serial_ctrl #(.N(8), .DIV_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .abort    (abort),
        .sdi      (sdi),
`ifdef USR_CTRL_LOOPBACK_EN
        .loopback (loopback),
`endif
        .sdo      (sdo),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every rx_valid strobe must match the oldest queued word.
    always @(negedge clk) begin
        if (!rst && bus.rx_valid) begin
            if (sb.size() == 0) begin
                chk("rx_unexpected", 32'(bus.rx_valid), 32'd0);
            end else begin
                chk("rx_data", 32'(bus.rx_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transfer. stop_at > 0 aborts (or resets, if use_rst) on that SHIFT
    // cycle (1-based) instead of completing.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] sdi_word,
                        input logic [7:0] exp_rx, input bit msb, input int d,
                        input int stop_at, input bit use_rst);
        int cy;
        int wait_n;
        logic exp_bit;
        cy = 0;
        wait_n = 0;
        @(negedge clk);
        while (!bus.tx_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk("tx_ready_idle", 32'(bus.tx_ready), 32'd1);
        bus.tx_valid  = 1'b1;
        bus.tx_data   = tx;
        bus.msb_first = msb;
        bus.div       = 8'(d);
        @(posedge clk);
        if (stop_at == 0) sb.push_back(exp_rx);
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.div      = 8'hFF;
        bus.msb_first = ~msb;
        for (int k = 0; k < 8; k++) begin
            sdi = msb ? sdi_word[7-k] : sdi_word[k];
            exp_bit = msb ? tx[7-k] : tx[k];
            for (int c = 0; c <= d; c++) begin
                cy++;
                if (cy == stop_at) begin
                    if (use_rst) begin
                        rst = 1'b1;
                        #1;
                        chk("rst_sdo", 32'(sdo), 32'd0);
                        chk("rst_busy", 32'(busy), 32'd0);
                        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
                        @(posedge clk);
                        #1;
                        rst = 1'b0;
                        @(negedge clk);
                        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
                        chk("rst_busy_after", 32'(busy), 32'd0);
                        last_rx = 8'h00;
                        chk("rst_rx_data", 32'(bus.rx_data), 32'(last_rx));
                    end else begin
                        abort = 1'b1;
                        @(negedge clk);
                        chk("abort_tx_ready", 32'(bus.tx_ready), 32'd0);
                        chk("abort_busy_during", 32'(busy), 32'd1);
                        @(posedge clk);
                        #1;
                        abort = 1'b0;
                        @(negedge clk);
                        chk("abort_busy_after", 32'(busy), 32'd0);
                        chk("abort_sdo", 32'(sdo), 32'd0);
                        chk("abort_tx_ready_after", 32'(bus.tx_ready), 32'd1);
                        chk("abort_rx_data_held", 32'(bus.rx_data), 32'(last_rx));
                    end
                    return;
                end
                @(negedge clk);
                chk("sdo_bit", 32'(sdo), 32'(exp_bit));
                chk("busy_shift", 32'(busy), 32'd1);
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        chk("rx_valid_latency", 32'(bus.rx_valid), 32'd1);
        chk("done_tx_ready", 32'(bus.tx_ready), 32'd0);
        chk("done_sdo", 32'(sdo), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("idle_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("rx_data_held", 32'(bus.rx_data), 32'(exp_rx));
        last_rx = exp_rx;
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        int dd;
        bit m;
        rst           = 1'b1;
        abort         = 1'b0;
        sdi           = 1'b0;
        loopback      = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        bus.msb_first = 1'b0;
        bus.div       = 8'h00;
        last_rx       = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sdo", 32'(sdo), 32'd0);
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx_ready", 32'(bus.tx_ready), 32'd1);

        xfer(8'hA5, 8'h3C, 8'h3C, 1'b1, 0, 0, 1'b0);
        xfer(8'h01, 8'h80, 8'h80, 1'b0, 0, 0, 1'b0);
        xfer(8'hF0, 8'h96, 8'h96, 1'b1, 3, 0, 1'b0);
        xfer(8'h77, 8'hFF, 8'h00, 1'b1, 0, 5, 1'b0);
        xfer(8'h5A, 8'h69, 8'h69, 1'b1, 0, 0, 1'b0);

        // abort together with tx_valid in IDLE: nothing is accepted
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hEE;
        abort        = 1'b1;
        #1;
        chk("abort_idle_tx_ready", 32'(bus.tx_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        abort        = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);

        xfer(8'h33, 8'hAA, 8'h00, 1'b1, 1, 3, 1'b1);
        xfer(8'h81, 8'h42, 8'h42, 1'b0, 2, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            m  = 1'($urandom_range(0, 1));
            dd = int'($urandom_range(0, 2));
            xfer(a, b, b, m, dd, 0, 1'b0);
        end

`ifdef USR_CTRL_LOOPBACK_EN
        loopback = 1'b1;
        xfer(8'hC3, 8'h00, 8'hC3, 1'b1, 0, 0, 1'b0);
        xfer(8'h3A, 8'h00, 8'h3A, 1'b0, 1, 0, 1'b0);
        loopback = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
